// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
// Shared declarations for the carry-save final-merge block.
//   state_t  : IDLE / BUSY / DONE controller states
//   ceil_div : integer ceiling divide, used to size the number of slice cycles
// -----------------------------------------------------------------------------
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices needed to cover a WIDTH-bit operand.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 32'sd1) / den;
    endfunction

endpackage

// File: rtl/csa_final_merge_chunk_add.sv
// -----------------------------------------------------------------------------
// fa_cell / merge_chunk_add
// Combinational slice adder for the final merge.
//   fa_cell         : single-bit full adder
//                     a_i, b_i, ci_i -> s_o, co_o
//   merge_chunk_add : CHUNK_BITS-wide ripple of fa_cell instances
//                     a_i[CHUNK_BITS], b_i[CHUNK_BITS], cin_i -> sum_o, cout_o
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module merge_chunk_add #(
    parameter int CHUNK_BITS = 4
) (
    input  logic [CHUNK_BITS-1:0] a_i,
    input  logic [CHUNK_BITS-1:0] b_i,
    input  logic                  cin_i,
    output logic [CHUNK_BITS-1:0] sum_o,
    output logic                  cout_o
);
    // carry_s[k] is the carry into bit k; carry_s[CHUNK_BITS] leaves the slice
    logic [CHUNK_BITS:0] carry_s;

    assign carry_s[0] = cin_i;

    for (genvar k = 0; k < CHUNK_BITS; k++) begin : g_fa
        fa_cell u_fa (
            .a_i  (a_i[k]),
            .b_i  (b_i[k]),
            .ci_i (carry_s[k]),
            .s_o  (sum_o[k]),
            .co_o (carry_s[k+1])
        );
    end

    assign cout_o = carry_s[CHUNK_BITS];
endmodule

// File: rtl/csa_final_merge.sv
// -----------------------------------------------------------------------------
// csa_final_merge
// Resolves the final sum/carry row of a carry-save multiplier array into a
// binary product, one CHUNK_BITS slice per cycle, LSB slice first.
//   hi      = ({1'b0, sum_vec[W-1:1]} + carry_vec) mod 2^W
//   product = {hi, lo_bits}
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   sum_vec, carry_vec    : W-bit final carry-save row
//   lo_bits               : M already-resolved low product bits
//   out_valid / out_ready : product handshake (valid only in DONE)
//   product               : W+M-bit registered result
//   ovf_err               : sticky carry-out-of-bit-W-1 flag, only present when
//                           CSA_MERGE_OVF_CHK_EN is defined
// -----------------------------------------------------------------------------
module csa_final_merge
    import csa_pkg::*;
#(
    parameter int MAX_MLTCND_BITS = 12,
    parameter int MAX_MLTPLR_BITS = 9,
    parameter int CHUNK_BITS      = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [MAX_MLTCND_BITS-1:0]               sum_vec,
    input  logic [MAX_MLTCND_BITS-1:0]               carry_vec,
    input  logic [MAX_MLTPLR_BITS-1:0]               lo_bits,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [MAX_MLTCND_BITS+MAX_MLTPLR_BITS-1:0] product
`ifdef CSA_MERGE_OVF_CHK_EN
    ,
    output logic                                     ovf_err
`endif
);

    localparam int W     = MAX_MLTCND_BITS;
    localparam int M     = MAX_MLTPLR_BITS;
    localparam int C     = CHUNK_BITS;
    localparam int N     = ceil_div(W, C);
    localparam int NC    = N * C;
    // width of the final (possibly truncated) slice
    localparam int LAST  = W - (N - 1) * C;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t            state_q;
    logic [NC-1:0]     a_q;        // shifted sum row, consumed C bits per cycle
    logic [NC-1:0]     b_q;        // carry row, consumed C bits per cycle
    logic [NC-1:0]     res_q;      // result slices shift in from the top
    logic [M-1:0]      lo_q;
    logic [IDX_W-1:0]  idx_q;
    logic              cin_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [W+M-1:0]    product_q;

    logic [C-1:0]      chunk_sum_s;
    logic              chunk_cout_s;
    logic [NC+C-1:0]   res_wide_s;
    logic [NC-1:0]     res_d;
    logic              last_slice_s;

    merge_chunk_add #(
        .CHUNK_BITS (C)
    ) u_chunk_add (
        .a_i    (a_q[C-1:0]),
        .b_i    (b_q[C-1:0]),
        .cin_i  (cin_q),
        .sum_o  (chunk_sum_s),
        .cout_o (chunk_cout_s)
    );

    // Next result image: new slice enters at the top, after N cycles slice 0
    // has drifted down to bit 0.
    always_comb begin
        res_wide_s   = {chunk_sum_s, res_q};
        res_d        = res_wide_s[NC+C-1:C];
        last_slice_s = (idx_q == IDX_LAST);
    end

`ifdef CSA_MERGE_OVF_CHK_EN
    logic              ovf_q;
    logic [C:0]        chunk_full_s;
    logic              last_carry_s;

    // Carry out of bit W-1: operand bits above W are zero, so for a truncated
    // final slice the carry appears at bit LAST of the slice sum.
    always_comb begin
        chunk_full_s = {chunk_cout_s, chunk_sum_s};
        last_carry_s = chunk_full_s[LAST];
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q == BUSY) && last_slice_s && last_carry_s) begin
            ovf_q <= 1'b1;
        end else begin
            ovf_q <= ovf_q;
        end
    end

    assign ovf_err = ovf_q;
`endif

    // Controller, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            lo_q        <= '0;
            idx_q       <= '0;
            cin_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= NC'(sum_vec >> 1);
                        b_q        <= NC'(carry_vec);
                        lo_q       <= lo_bits;
                        res_q      <= '0;
                        idx_q      <= '0;
                        cin_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    a_q   <= a_q >> C;
                    b_q   <= b_q >> C;
                    res_q <= res_d;
                    cin_q <= chunk_cout_s;
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_slice_s) begin
                        // carry beyond bit W-1 is dropped by the truncation
                        product_q   <= {res_d[W-1:0], lo_q};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_csa_final_merge.sv
module tb_csa_final_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] sum_vec;
    logic [11:0] carry_vec;
    logic [8:0]  lo_bits;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] product;
`ifdef CSA_MERGE_OVF_CHK_EN
    logic        ovf_err;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic ovf_model = 1'b0;

    csa_final_merge dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .lo_bits   (lo_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
`ifdef CSA_MERGE_OVF_CHK_EN
        ,
        .ovf_err   (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] s;
        logic [11:0] c;
        logic [8:0]  lo;
        logic [20:0] prod;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_ovf(input string name);
`ifdef CSA_MERGE_OVF_CHK_EN
        check(name, {31'd0, ovf_err}, {31'd0, ovf_model});
`endif
    endtask

    // One full transaction; hold = cycles out_ready stays low in DONE.
    task automatic run_op(input logic [11:0] s, input logic [11:0] c, input logic [8:0] lo,
                          input logic [20:0] exp, input logic ovf, input int hold);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        sum_vec   = s;
        carry_vec = c;
        lo_bits   = lo;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        // garbage during BUSY must not reach the product
        sum_vec   = 12'($urandom);
        carry_vec = 12'($urandom);
        lo_bits   = 9'($urandom);
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 32'd3);
        check("product", {11'd0, product}, {11'd0, exp});
        ovf_model = ovf_model | ovf;
        check_ovf("ovf_err");
        for (int h = 0; h < hold; h++) begin
            // a new request during DONE must be ignored
            in_valid  = 1'b1;
            sum_vec   = 12'($urandom);
            carry_vec = 12'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_product", {11'd0, product}, {11'd0, exp});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        vecs[0] = '{12'h002, 12'h001, 9'h1A3, 21'h0005A3, 1'b0};
        vecs[1] = '{12'h01E, 12'h001, 9'h000, 21'h002000, 1'b0};
        vecs[2] = '{12'hFFE, 12'h7FF, 9'h1FF, 21'h1FFDFF, 1'b0};
        vecs[3] = '{12'h000, 12'h000, 9'h000, 21'h000000, 1'b0};
        vecs[4] = '{12'h001, 12'h000, 9'h001, 21'h000001, 1'b0};
        vecs[5] = '{12'h000, 12'hFFF, 9'h0AA, 21'h1FFEAA, 1'b0};
        vecs[6] = '{12'h555, 12'h0AB, 9'h155, 21'h06AB55, 1'b0};
        vecs[7] = '{12'hFFF, 12'hFFF, 9'h000, 21'h0FFC00, 1'b1};
        vecs[8] = '{12'h002, 12'h001, 9'h1A3, 21'h0005A3, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_vec   = 12'h000;
        carry_vec = 12'h000;
        lo_bits   = 9'h000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_product", {11'd0, product}, 32'd0);
        check_ovf("rst_ovf");

        // vector 8 follows the overflow case so the flag must stay set
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].s, vecs[i].c, vecs[i].lo, vecs[i].prod, vecs[i].ovf, 0);
        end

        // back-pressure: out_ready low for 5 cycles in DONE
        run_op(12'h01E, 12'h001, 9'h0F0, 21'h0020F0, 1'b0, 5);

        // reset in the second BUSY cycle abandons the operation
        sum_vec   = 12'h002;
        carry_vec = 12'h001;
        lo_bits   = 9'h1A3;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ovf_model = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_product", {11'd0, product}, 32'd0);
        check_ovf("abort_ovf");
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 32'd0);
        check("abort_product_late", {11'd0, product}, 32'd0);

        // still functional after the abort
        run_op(12'h01E, 12'h001, 9'h000, 21'h002000, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/csa_final_merge.md
CSA_FINAL_MERGE -- requirements
Module: csa_final_merge

Interface
REQ-001 SHALL have parameter MAX_MLTCND_BITS, default 12, multiplicand width W (width of the sum/carry vectors).
REQ-002 SHALL have parameter MAX_MLTPLR_BITS, default 9, multiplier width M (count of already-resolved low product bits).
REQ-003 SHALL have parameter CHUNK_BITS, default 4, bits resolved per cycle; legal range 1..W.
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, an operand set is presented.
REQ-007 SHALL have port in_ready, output, 1, block can accept an operand set.
REQ-008 SHALL have port sum_vec, input, W, final-row partial sum from the carry-save reduction array.
REQ-009 SHALL have port carry_vec, input, W, final-row partial carry from the carry-save reduction array.
REQ-010 SHALL have port lo_bits, input, M, low product bits already resolved by the array.
REQ-011 SHALL have port out_valid, output, 1, product is valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the product.
REQ-013 SHALL have port product, output, W+M, merged product.

Function
REQ-014 SHALL compute hi = ({1'b0, sum_vec[W-1:1]} + carry_vec) mod 2^W and product = {hi, lo_bits}.
REQ-015 SHALL use FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid&&in_ready, SHALL register sum_vec, carry_vec, lo_bits, clear the chunk index and carry-in, then go to BUSY.
REQ-017 BUSY: SHALL add one CHUNK_BITS slice per cycle, LSB slice first, propagating the carry between slices; the last slice SHALL be truncated to the remaining W bits.
REQ-018 SHALL use N = ceil(W/CHUNK_BITS) BUSY cycles; out_valid SHALL rise exactly N cycles after the accepting edge (N=3 at defaults).
REQ-019 DONE: SHALL hold product stable until out_ready=1, then go to IDLE; it SHALL NOT accept new input in the same cycle.
REQ-020 Input ports SHALL be ignored outside the IDLE accept cycle; changes during BUSY/DONE SHALL NOT affect product.
REQ-021 Carry-out beyond bit W-1 SHALL be discarded.

Reset
REQ-022 rst=1 SHALL force IDLE, in_ready=1 on the following cycle, out_valid=0, product=0, and chunk index and carry=0.
REQ-023 rst asserted during BUSY or DONE SHALL abandon the operation; no out_valid SHALL follow.

Configuration
REQ-024 With CSA_MERGE_OVF_CHK_EN defined, SHALL add output port ovf_err (1 bit) that is set sticky when the final slice produces a nonzero carry-out and is cleared only by rst.
REQ-025 Without CSA_MERGE_OVF_CHK_EN, SHALL have no ovf_err port and no related logic.

Structure
REQ-026 Package csa_pkg SHALL hold the FSM state enum typedef and a ceil-divide function for N.
REQ-027 Slice addition SHALL be a combinational sub-module merge_chunk_add (CHUNK_BITS-wide ripple of fa_cell instances, with carry-in and carry-out).

Verification
REQ-028 sum_vec=12'h002, carry_vec=12'h001, lo_bits=9'h1A3 -> product=21'h0005A3 three cycles after accept.
REQ-029 sum_vec=12'h01E, carry_vec=12'h001, lo_bits=0 -> hi=12'h010 (carry crosses slice 0->1), product=21'h002000.
REQ-030 sum_vec=12'hFFE, carry_vec=12'h7FF, lo_bits=9'h1FF -> product=21'h1FFDFF; ovf_err stays 0 when enabled.
REQ-031 sum_vec=12'hFFF, carry_vec=12'hFFF -> hi=12'h7FE, carry discarded; ovf_err=1 and sticky when enabled.
REQ-032 out_ready held 0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0; on out_ready=1 return to IDLE next cycle.
REQ-033 rst pulsed in second BUSY cycle -> out_valid never asserts, product=0, and in_ready=1 on the cycle after rst.
